// File: rtl/chrono_pkg.sv
// Shared constants for the multi-channel min:sec timer: field widths and command opcodes.
package chrono_pkg;

  localparam int SEC_W = 6;
  localparam int MIN_W = 7;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_LOAD     = 3'd1;
  localparam logic [2:0] OP_START    = 3'd2;
  localparam logic [2:0] OP_STOP     = 3'd3;
  localparam logic [2:0] OP_CLEAR    = 3'd4;
  localparam logic [2:0] OP_LAP      = 3'd5;
  localparam logic [2:0] OP_SET_MODE = 3'd6;

  function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] sec);
    return (sec > SEC_MAX) ? SEC_MAX : sec;
  endfunction

endpackage

// File: rtl/chrono_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_HZ/TICK_HZ clocks.
module chrono_tick_gen #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("chrono_tick_gen: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic [CW-1:0] cnt;

  // Tick is decoded straight from the count so it lines up with the DIV-1 state.
  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/chrono_multi_timer.sv
// N_CH independent min:sec stopwatch/timer channels driven by one shared tick and a command port.
module chrono_multi_timer
  import chrono_pkg::*;
#(
  parameter  int CLK_HZ  = 100_000_000,
  parameter  int TICK_HZ = 1,
  parameter  int N_CH    = 4,
  parameter  int MAX_MIN = 99,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CH_W-1:0]  cmd_ch,
  input  logic [2:0]       cmd_op,
  input  logic [MIN_W-1:0] cmd_min,
  input  logic [SEC_W-1:0] cmd_sec,
  input  logic             cmd_down,
  input  logic             cmd_reload,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [MIN_W-1:0] rd_min,
  output logic [SEC_W-1:0] rd_sec,
  output logic [MIN_W-1:0] rd_lap_min,
  output logic [SEC_W-1:0] rd_lap_sec,
  output logic [N_CH-1:0]  running,
  output logic [N_CH-1:0]  expired,
  output logic [N_CH-1:0]  expire_pulse,
  output logic             tick
);

  localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("chrono_multi_timer: N_CH must be in 1..16");
  end
  if (MAX_MIN < 0 || MAX_MIN > 127) begin : g_bad_max
    $error("chrono_multi_timer: MAX_MIN must be in 0..127");
  end

  chrono_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // The tick owns its cycle, so a command and a tick never update a channel together.
  logic cmd_fire;
  assign cmd_ready = ~tick;
  assign cmd_fire  = cmd_valid & cmd_ready;

  logic [MIN_W-1:0] load_min;
  logic [SEC_W-1:0] load_sec;
  assign load_min = (cmd_min > MAX_MIN_V) ? MAX_MIN_V : cmd_min;
  assign load_sec = clamp_sec(cmd_sec);

  logic [MIN_W-1:0] ch_min     [N_CH];
  logic [SEC_W-1:0] ch_sec     [N_CH];
  logic [MIN_W-1:0] ch_lap_min [N_CH];
  logic [SEC_W-1:0] ch_lap_sec [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [MIN_W-1:0] cnt_min, lap_min, rel_min;
    logic [SEC_W-1:0] cnt_sec, lap_sec, rel_sec;
    logic             down, reload, run, expd, pulse;
    logic             sel, cnt_zero, rel_nz;

    assign sel      = cmd_fire && (cmd_ch == CH_W'(i));
    assign cnt_zero = (cnt_min == '0) && (cnt_sec == '0);
    assign rel_nz   = (rel_min != '0) || (rel_sec != '0);

    // Tick advances a running channel; otherwise an accepted command for this channel applies.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_min <= '0;
        cnt_sec <= '0;
        lap_min <= '0;
        lap_sec <= '0;
        rel_min <= '0;
        rel_sec <= '0;
        down    <= 1'b0;
        reload  <= 1'b0;
        run     <= 1'b0;
        expd    <= 1'b0;
        pulse   <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (tick && run) begin
          if (!down) begin
            if (cnt_sec != SEC_MAX) begin
              cnt_sec <= cnt_sec + 1'b1;
            end else if (cnt_min != MAX_MIN_V) begin
              cnt_sec <= '0;
              cnt_min <= cnt_min + 1'b1;
            end else begin
              run   <= 1'b0;
              expd  <= 1'b1;
              pulse <= 1'b1;
            end
          end else if (cnt_zero) begin
            cnt_min <= rel_min;
            cnt_sec <= rel_sec;
          end else begin
            if (cnt_sec != '0) begin
              cnt_sec <= cnt_sec - 1'b1;
            end else begin
              cnt_min <= cnt_min - 1'b1;
              cnt_sec <= SEC_MAX;
            end
            if (cnt_min == '0 && cnt_sec == 6'd1) begin
              pulse <= 1'b1;
              expd  <= 1'b1;
              run   <= reload && rel_nz;
            end
          end
        end else if (sel) begin
          case (cmd_op)
            OP_LOAD: begin
              cnt_min <= load_min;
              cnt_sec <= load_sec;
              rel_min <= load_min;
              rel_sec <= load_sec;
              run     <= 1'b0;
              expd    <= 1'b0;
            end
            OP_START: begin
              if (!(down && cnt_zero)) begin
                run  <= 1'b1;
                expd <= 1'b0;
              end
            end
            OP_STOP: begin
              run <= 1'b0;
            end
            OP_CLEAR: begin
              cnt_min <= '0;
              cnt_sec <= '0;
              lap_min <= '0;
              lap_sec <= '0;
              run     <= 1'b0;
              expd    <= 1'b0;
            end
            OP_LAP: begin
              lap_min <= cnt_min;
              lap_sec <= cnt_sec;
            end
            OP_SET_MODE: begin
              down   <= cmd_down;
              reload <= cmd_down & cmd_reload;
              run    <= 1'b0;
            end
            default: begin
            end
          endcase
        end
      end
    end

    assign running[i]      = run;
    assign expired[i]      = expd;
    assign expire_pulse[i] = pulse;
    assign ch_min[i]       = cnt_min;
    assign ch_sec[i]       = cnt_sec;
    assign ch_lap_min[i]   = lap_min;
    assign ch_lap_sec[i]   = lap_sec;
  end

  logic [MIN_W-1:0] sel_min, sel_lap_min;
  logic [SEC_W-1:0] sel_sec, sel_lap_sec;

  // Out-of-range select falls through to zero rather than indexing past the array.
  always_comb begin
    sel_min     = '0;
    sel_sec     = '0;
    sel_lap_min = '0;
    sel_lap_sec = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (rd_ch == CH_W'(k)) begin
        sel_min     = ch_min[k];
        sel_sec     = ch_sec[k];
        sel_lap_min = ch_lap_min[k];
        sel_lap_sec = ch_lap_sec[k];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_min     <= '0;
      rd_sec     <= '0;
      rd_lap_min <= '0;
      rd_lap_sec <= '0;
    end else begin
      rd_min     <= sel_min;
      rd_sec     <= sel_sec;
      rd_lap_min <= sel_lap_min;
      rd_lap_sec <= sel_lap_sec;
    end
  end

endmodule

// File: tb/tb_chrono_multi_timer.sv
// Bench for chrono_multi_timer: total-seconds reference model checked every cycle plus directed literal checks.
module tb_chrono_multi_timer;
  import chrono_pkg::*;

  localparam int DIV = 10;
  localparam int TOP = 99 * 60 + 59;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_down, cmd_reload, tick;
  logic [1:0] cmd_ch, rd_ch;
  logic [2:0] cmd_op;
  logic [6:0] cmd_min, rd_min, rd_lap_min;
  logic [5:0] cmd_sec, rd_sec, rd_lap_sec;
  logic [3:0] running, expired, expire_pulse;

  logic       en3, cmd_valid3, cmd_ready3, tick3;
  logic [6:0] rd_min3, rd_lap_min3;
  logic [5:0] rd_sec3, rd_lap_sec3;
  logic [2:0] running3, expired3, expire_pulse3;
  assign cmd_valid3 = cmd_valid && en3;

  int checks = 0;
  int failures = 0;
  int last_wait = 0;
  bit cmp_on = 0;

  always #5 clk = ~clk;

  chrono_multi_timer #(.CLK_HZ(10), .TICK_HZ(1), .N_CH(4), .MAX_MIN(99)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_op(cmd_op), .cmd_min(cmd_min), .cmd_sec(cmd_sec),
    .cmd_down(cmd_down), .cmd_reload(cmd_reload), .rd_ch(rd_ch),
    .rd_min(rd_min), .rd_sec(rd_sec), .rd_lap_min(rd_lap_min), .rd_lap_sec(rd_lap_sec),
    .running(running), .expired(expired), .expire_pulse(expire_pulse), .tick(tick)
  );

  // Three-channel instance so channel index 3 is out of range.
  chrono_multi_timer #(.CLK_HZ(10), .TICK_HZ(1), .N_CH(3), .MAX_MIN(99)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_ch(cmd_ch), .cmd_op(cmd_op), .cmd_min(cmd_min), .cmd_sec(cmd_sec),
    .cmd_down(cmd_down), .cmd_reload(cmd_reload), .rd_ch(rd_ch),
    .rd_min(rd_min3), .rd_sec(rd_sec3), .rd_lap_min(rd_lap_min3), .rd_lap_sec(rd_lap_sec3),
    .running(running3), .expired(expired3), .expire_pulse(expire_pulse3), .tick(tick3)
  );

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: counts held as total seconds, edges counted since reset release.
  int m_cnt[4], m_lap[4], m_rel[4];
  bit [3:0] m_down, m_rl, m_run, m_exp, m_pulse;
  int m_cyc = 0;
  int m_rd_cnt = 0, m_rd_lap = 0;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        m_cnt[i] = 0; m_lap[i] = 0; m_rel[i] = 0;
      end
      m_down = 0; m_rl = 0; m_run = 0; m_exp = 0; m_pulse = 0;
      m_cyc = 0; m_rd_cnt = 0; m_rd_lap = 0;
    end else begin
      bit t;
      int ch, mn, sc;
      t = (m_cyc % DIV) == DIV - 1;
      m_rd_cnt = m_cnt[rd_ch];
      m_rd_lap = m_lap[rd_ch];
      m_pulse = 0;
      if (t) begin
        for (int i = 0; i < 4; i++) begin
          if (m_run[i]) begin
            if (!m_down[i]) begin
              if (m_cnt[i] == TOP) begin
                m_run[i] = 0; m_exp[i] = 1; m_pulse[i] = 1;
              end else begin
                m_cnt[i]++;
              end
            end else if (m_cnt[i] == 0) begin
              m_cnt[i] = m_rel[i];
            end else begin
              m_cnt[i]--;
              if (m_cnt[i] == 0) begin
                m_pulse[i] = 1; m_exp[i] = 1;
                m_run[i] = m_rl[i] && (m_rel[i] != 0);
              end
            end
          end
        end
      end else if (cmd_valid) begin
        ch = int'(cmd_ch);
        mn = (int'(cmd_min) > 99) ? 99 : int'(cmd_min);
        sc = (int'(cmd_sec) > 59) ? 59 : int'(cmd_sec);
        case (cmd_op)
          OP_LOAD:     begin m_cnt[ch] = mn * 60 + sc; m_rel[ch] = m_cnt[ch]; m_run[ch] = 0; m_exp[ch] = 0; end
          OP_START:    if (!(m_down[ch] && m_cnt[ch] == 0)) begin m_run[ch] = 1; m_exp[ch] = 0; end
          OP_STOP:     m_run[ch] = 0;
          OP_CLEAR:    begin m_cnt[ch] = 0; m_lap[ch] = 0; m_run[ch] = 0; m_exp[ch] = 0; end
          OP_LAP:      m_lap[ch] = m_cnt[ch];
          OP_SET_MODE: begin m_down[ch] = cmd_down; m_rl[ch] = cmd_down && cmd_reload; m_run[ch] = 0; end
          default:     ;
        endcase
      end
      m_cyc++;
    end
  end

  function automatic int as_mmss(input int total);
    return (total / 60) * 100 + (total % 60);
  endfunction

  // Every-cycle comparison against the model, on the falling edge.
  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      bit et;
      et = reset && ((m_cyc % DIV) == DIV - 1);
      check("cmp_tick", int'(tick), int'(et));
      check("cmp_ready", int'(cmd_ready), int'(!et));
      check("cmp_rd_cnt", int'(rd_min) * 100 + int'(rd_sec), as_mmss(m_rd_cnt));
      check("cmp_rd_lap", int'(rd_lap_min) * 100 + int'(rd_lap_sec), as_mmss(m_rd_lap));
      check("cmp_running", int'(running), int'(m_run));
      check("cmp_expired", int'(expired), int'(m_exp));
      check("cmp_pulse", int'(expire_pulse), int'(m_pulse));
      check("cmp_d3_tick", int'(tick3) * 2 + int'(cmd_ready3), int'(et) * 2 + int'(!et));
      check("cmp_d3_flags", int'({running3, expired3, expire_pulse3}), 0);
      check("cmp_d3_lap", int'(rd_lap_min3) * 100 + int'(rd_lap_sec3), 0);
    end
  end

  task automatic check_rd(input string name, input int mn, input int sc);
    check(name, int'(rd_min) * 100 + int'(rd_sec), mn * 100 + sc);
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting clock.
  task automatic send_cmd(input logic [1:0] ch, input logic [2:0] op, input int mn, input int sc,
                          input logic dn, input logic rl);
    int w = 0;
    #1;
    cmd_ch = ch; cmd_op = op; cmd_min = 7'(mn); cmd_sec = 6'(sc);
    cmd_down = dn; cmd_reload = rl; cmd_valid = 1'b1;
    while (!cmd_ready && w < 20) begin
      @(negedge clk); #1; w++;
    end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("[TB] FAIL cmd_timeout ready=%0d want=1", cmd_ready);
    end
    last_wait = w;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Returns at the falling edge just after the n-th tick clock edge.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      do begin
        @(negedge clk); guard++;
      end while (!tick && guard < 40);
      if (!tick) begin
        checks++; failures++;
        $display("[TB] FAIL tick_timeout tick=%0d want=1", tick);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_ch = '0; cmd_op = '0; cmd_min = '0; cmd_sec = '0;
    cmd_down = 1'b0; cmd_reload = 1'b0; rd_ch = '0; en3 = 1'b0;
    repeat (3) @(posedge clk);
    cmp_on = 1;
    #1 reset = 1'b1;

    // Idle after release: tick on cycles 10, 20, 30 only.
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      check("tick_timing", int'(tick), int'(n % 10 == 0));
      check("ready_timing", int'(cmd_ready), int'(n % 10 != 0));
      check("rd_idle", int'({rd_min, rd_sec, rd_lap_min, rd_lap_sec}), 0);
    end

    rd_ch = 2'd1;
    send_cmd(2'd1, OP_SET_MODE, 0, 0, 1'b1, 1'b0);
    send_cmd(2'd1, OP_LOAD, 0, 3, 1'b0, 1'b0);
    send_cmd(2'd1, OP_START, 0, 0, 1'b0, 1'b0);
    wait_ticks(1);
    check("cd_running", int'(running[1]), 1);
    @(negedge clk); check_rd("cd_0_02", 0, 2);
    wait_ticks(1);
    @(negedge clk); check_rd("cd_0_01", 0, 1);
    wait_ticks(1);
    check("cd_pulse", int'(expire_pulse[1]), 1);
    check("cd_expired", int'(expired[1]), 1);
    check("cd_stopped", int'(running[1]), 0);
    @(negedge clk);
    check("cd_pulse_one", int'(expire_pulse[1]), 0);
    check_rd("cd_0_00", 0, 0);
    send_cmd(2'd1, OP_START, 0, 0, 1'b0, 1'b0);
    check("cd_restart_blocked", int'(running[1]), 0);
    check("cd_flag_kept", int'(expired[1]), 1);

    rd_ch = 2'd2;
    send_cmd(2'd2, OP_SET_MODE, 0, 0, 1'b1, 1'b1);
    send_cmd(2'd2, OP_LOAD, 1, 0, 1'b0, 1'b0);
    send_cmd(2'd2, OP_START, 0, 0, 1'b0, 1'b0);
    wait_ticks(1);
    @(negedge clk); check_rd("ar_0_59", 0, 59);
    wait_ticks(58);
    wait_ticks(1);
    check("ar_pulse", int'(expire_pulse[2]), 1);
    check("ar_still_running", int'(running[2]), 1);
    @(negedge clk); check_rd("ar_0_00", 0, 0);
    wait_ticks(1);
    @(negedge clk); check_rd("ar_reloaded", 1, 0);
    check("ar_running_after", int'(running[2]), 1);
    send_cmd(2'd2, OP_STOP, 0, 0, 1'b0, 1'b0);

    rd_ch = 2'd0;
    send_cmd(2'd0, OP_LOAD, 99, 58, 1'b0, 1'b0);
    send_cmd(2'd0, OP_START, 0, 0, 1'b0, 1'b0);
    wait_ticks(1);
    @(negedge clk); check_rd("up_99_59", 99, 59);
    wait_ticks(1);
    check("up_pulse", int'(expire_pulse[0]), 1);
    check("up_stopped", int'(running[0]), 0);
    check("up_expired", int'(expired[0]), 1);
    wait_ticks(1);
    @(negedge clk); check_rd("up_held", 99, 59);

    rd_ch = 2'd3;
    send_cmd(2'd3, OP_CLEAR, 0, 0, 1'b0, 1'b0);
    send_cmd(2'd3, OP_START, 0, 0, 1'b0, 1'b0);
    wait_ticks(5);
    send_cmd(2'd3, OP_LAP, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("lap_value", int'(rd_lap_min) * 100 + int'(rd_lap_sec), 5);
    check_rd("lap_cnt", 0, 5);
    wait_ticks(1);
    @(negedge clk);
    check_rd("lap_continues", 0, 6);
    check("lap_kept", int'(rd_lap_min) * 100 + int'(rd_lap_sec), 5);

    // 63 is the largest value the 6-bit seconds field can carry.
    send_cmd(2'd3, OP_LOAD, 120, 63, 1'b0, 1'b0);
    @(negedge clk);
    check_rd("clamp", 99, 59);
    check("clamp_stopped", int'(running[3]), 0);

    rd_ch = 2'd0;
    for (int g = 0; g < 15 && !tick; g++) @(negedge clk);
    send_cmd(2'd0, OP_LOAD, 0, 7, 1'b0, 1'b0);
    check("holdoff_wait", last_wait, 1);
    @(negedge clk); check_rd("holdoff_load", 0, 7);

    en3 = 1'b1;
    send_cmd(2'd3, OP_LOAD, 5, 5, 1'b0, 1'b0);
    send_cmd(2'd3, OP_START, 0, 0, 1'b0, 1'b0);
    send_cmd(2'd2, OP_LOAD, 4, 4, 1'b0, 1'b0);
    en3 = 1'b0;
    rd_ch = 2'd3;
    @(negedge clk);
    check("n3_oob_rd", int'(rd_min3) * 100 + int'(rd_sec3), 0);
    check("n3_oob_run", int'(running3), 0);
    rd_ch = 2'd2;
    @(negedge clk);
    check("n3_ch2_rd", int'(rd_min3) * 100 + int'(rd_sec3), 404);

    rd_ch = 2'd1;
    send_cmd(2'd1, OP_LOAD, 0, 30, 1'b0, 1'b0);
    send_cmd(2'd1, OP_START, 0, 0, 1'b0, 1'b0);
    check("mid_running", int'(running[1]), 1);
    #2 reset = 1'b0;
    #1;
    check("rst_rd", int'({rd_min, rd_sec, rd_lap_min, rd_lap_sec}), 0);
    check("rst_flags", int'({running, expired, expire_pulse}), 0);
    check("rst_tick", int'(tick), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_rd("rst_ch1_zero", 0, 0);
    check("rst_ch1_stopped", int'(running[1]), 0);
    check("rst_ready", int'(cmd_ready), 1);
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
